note_draw_sequencer: RTL

NOTE_DRAW_SEQUENCER -- requirements
Module: note_draw_sequencer

---
 rtl/note_draw_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/note_draw_sequencer.sv
// note_draw_sequencer: scans the note table and streams each active entry's 16x16 key sprite to the VGA plotter.
// Ports: clock/reset (sync, active-low); start, frame_id request a pass; entry_idx -> loc_x/loc_y/key_id (1-cycle ROM);
// spr_i/spr_j/spr_id/spr_id2 -> pix_colour (1-cycle loader); vga_x/vga_y/vga_colour/vga_plot plot port; busy, done status.
module note_draw_sequencer #(
  parameter int NUM_ENTRIES = 16,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] frame_id,
  output logic [3:0] entry_idx,
  input  logic [7:0] loc_x,
  input  logic [7:0] loc_y,
  input  logic [1:0] key_id,
  output logic [3:0] spr_i,
  output logic [5:0] spr_j,
  output logic [2:0] spr_id,
  output logic [1:0] spr_id2,
  input  logic [2:0] pix_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, FLUSH, NEXT, FIN} state_t;
  state_t state, state_n;
  logic [3:0] cnt, i, j, i_d, j_d;
  logic [2:0] fr;
  logic [1:0] k;
  logic [7:0] lx, ly;
  logic       v_d;
  logic [8:0] x_sum, y_sum;
  logic       last;
  assign last = cnt == 4'(NUM_ENTRIES - 1);
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      i <= '0;
      j <= '0;
      i_d <= '0;
      j_d <= '0;
      v_d <= 1'b0;
      fr <= '0;
      k <= '0;
      lx <= '0;
      ly <= '0;
    end else begin
      state <= state_n;
      v_d <= state == DRAW;
      i_d <= i;
      j_d <= j;
      if (state == IDLE && start) begin
        cnt <= '0;
        fr <= frame_id;
      end
      if (state == LATCH) begin
        lx <= loc_x;
        ly <= loc_y;
        k <= key_id;
        i <= '0;
        j <= '0;
      end
      if (state == DRAW) begin
        i <= i + 4'd1;
        if (i == 4'hF) j <= j + 4'd1;
      end
      if (state == NEXT && !last) cnt <= cnt + 4'd1;
    end
  end
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:  state_n = start ? FETCH : IDLE;
      FETCH: state_n = LATCH;
      LATCH: state_n = (loc_y == 8'hFF) ? NEXT : DRAW;
      DRAW:  state_n = (i == 4'hF && j == 4'hF) ? FLUSH : DRAW;
      FLUSH: state_n = NEXT;
      NEXT:  state_n = last ? FIN : FETCH;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // 9-bit sums so sprites hanging off the right/bottom edge are clipped, never wrapped
  assign x_sum = {1'b0, lx} + {5'd0, i_d};
  assign y_sum = {1'b0, ly} + {5'd0, j_d};
  assign entry_idx = cnt;
  assign spr_i = i;
  assign spr_j = {2'b00, j};
  assign spr_id = fr;
  assign spr_id2 = k;
  assign vga_plot = v_d && pix_colour != TRANSPARENT && x_sum < 9'd160 && y_sum < 9'd120;
  assign vga_x = v_d ? x_sum[7:0] : 8'd0;
  assign vga_y = v_d ? y_sum[6:0] : 7'd0;
  assign vga_colour = v_d ? pix_colour : 3'd0;
  assign busy = state != IDLE;
  assign done = state == FIN;
endmodule
